// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: ALU codes,
// opcode/funct values, FSM states and datapath mux selects.
package mc_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Next-PC source
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    // Destination register select
    localparam logic [1:0] GPR_RD   = 2'b00;
    localparam logic [1:0] GPR_RT   = 2'b01;
    localparam logic [1:0] GPR_R31  = 2'b10;

    // Register write-data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MDR   = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;

    // ALU operand selects
    localparam logic [1:0] SRCA_RS     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_SHAMT  = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps Op/Funct onto instruction
// classes, the EXEC-phase ALU code, immediate extension mode and an
// illegal flag for anything outside the supported set.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       is_rtype,
    output logic       is_imm,
    output logic       is_shamt,
    output logic       is_lw,
    output logic       is_sw,
    output logic       is_beq,
    output logic       is_bne,
    output logic       is_j,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_jalr,
    output logic       is_illegal,
    output logic [3:0] alu_code,
    output logic       ext_sign
);

    // classify the held instruction
    always_comb begin
        is_rtype   = 1'b0;
        is_imm     = 1'b0;
        is_shamt   = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        is_jalr    = 1'b0;
        is_illegal = 1'b0;
        alu_code   = ALU_NOP;
        ext_sign   = 1'b0;
        case (Op)
            OP_RTYPE: begin
                case (Funct)
                    FN_ADD, FN_ADDU: begin is_rtype = 1'b1; alu_code = ALU_ADD;  end
                    FN_SUB, FN_SUBU: begin is_rtype = 1'b1; alu_code = ALU_SUB;  end
                    FN_AND:          begin is_rtype = 1'b1; alu_code = ALU_AND;  end
                    FN_OR:           begin is_rtype = 1'b1; alu_code = ALU_OR;   end
                    FN_NOR:          begin is_rtype = 1'b1; alu_code = ALU_NOR;  end
                    FN_SLT:          begin is_rtype = 1'b1; alu_code = ALU_SLT;  end
                    FN_SLTU:         begin is_rtype = 1'b1; alu_code = ALU_SLTU; end
                    FN_SLL: begin
                        is_rtype = 1'b1;
                        is_shamt = 1'b1;
                        alu_code = ALU_SLL;
                    end
                    FN_SRL: begin
                        is_rtype = 1'b1;
                        is_shamt = 1'b1;
                        alu_code = ALU_SRL;
                    end
                    // variable shifts take the amount from rs, so operand A stays rs
                    FN_SLLV:         begin is_rtype = 1'b1; alu_code = ALU_SLL;  end
                    FN_SRLV:         begin is_rtype = 1'b1; alu_code = ALU_SRL;  end
                    FN_JR:           is_jr   = 1'b1;
                    FN_JALR:         is_jalr = 1'b1;
                    default:         is_illegal = 1'b1;
                endcase
            end
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            OP_BEQ:  begin is_beq = 1'b1; alu_code = ALU_SUB; ext_sign = 1'b1; end
            OP_BNE:  begin is_bne = 1'b1; alu_code = ALU_SUB; ext_sign = 1'b1; end
            OP_ADDI: begin is_imm = 1'b1; alu_code = ALU_ADD; ext_sign = 1'b1; end
            OP_SLTI: begin is_imm = 1'b1; alu_code = ALU_SLT; ext_sign = 1'b1; end
            OP_ANDI: begin is_imm = 1'b1; alu_code = ALU_AND; end
            OP_ORI:  begin is_imm = 1'b1; alu_code = ALU_OR;  end
            OP_LUI:  begin is_imm = 1'b1; alu_code = ALU_LUI; end
            OP_LW:   begin is_lw  = 1'b1; alu_code = ALU_ADD; ext_sign = 1'b1; end
            OP_SW:   begin is_sw  = 1'b1; alu_code = ALU_ADD; ext_sign = 1'b1; end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FSM sequencing, memory wait counter with
// optional timeout, and combinational datapath control outputs.
//
// state  | meaning
// FETCH  | read IR from memory at PC, PC <= PC+4 on mem_ready
// DECODE | branch target into ALUOut; jumps and illegal finish here
// EXEC   | ALU op / address calc / branch compare
// MEM    | data load or store at ALUOut, wait for mem_ready
// WB     | register-file write from ALUOut or MDR
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         NPCOp,
    output logic               RegWrite,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               EXTOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal,
    output logic               bus_err,
    output logic [2:0]         state
);

    // Timeout fires on the MEM_TIMEOUT-th consecutive wait cycle, i.e. when
    // the count of earlier wait cycles equals MEM_TIMEOUT-1.
    localparam bit              TO_EN   = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
    logic [3:0]       alu_sel;

    logic d_rtype, d_imm, d_shamt, d_lw, d_sw, d_beq, d_bne;
    logic d_j, d_jal, d_jr, d_jalr, d_illegal, d_ext;
    logic [3:0] d_alu;

    mc_decode u_decode (
        .Op         (Op),
        .Funct      (Funct),
        .is_rtype   (d_rtype),
        .is_imm     (d_imm),
        .is_shamt   (d_shamt),
        .is_lw      (d_lw),
        .is_sw      (d_sw),
        .is_beq     (d_beq),
        .is_bne     (d_bne),
        .is_j       (d_j),
        .is_jal     (d_jal),
        .is_jr      (d_jr),
        .is_jalr    (d_jalr),
        .is_illegal (d_illegal),
        .alu_code   (d_alu),
        .ext_sign   (d_ext)
    );

    assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign timeout = TO_EN && waiting && (wait_cnt == TO_LAST);

    // FSM state register and transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) state_q <= ST_DECODE;
                    else           state_q <= ST_FETCH;
                end
                ST_DECODE: begin
                    if (d_j || d_jal || d_jr || d_jalr || d_illegal)
                        state_q <= ST_FETCH;
                    else
                        state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (d_rtype || d_imm)  state_q <= ST_WB;
                    else if (d_lw || d_sw) state_q <= ST_MEM;
                    else                   state_q <= ST_FETCH;
                end
                ST_MEM: begin
                    if (mem_ready)    state_q <= d_lw ? ST_WB : ST_FETCH;
                    else if (timeout) state_q <= ST_FETCH;
                    else              state_q <= ST_MEM;
                end
                ST_WB:   state_q <= ST_FETCH;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Wait counter: counts consecutive memory wait cycles, zero elsewhere,
    // so it is already clear on every entry to FETCH or MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (waiting && !timeout) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Datapath controls decoded from state and instruction; all zero in reset
    always_comb begin
        mem_req  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        NPCOp    = NPC_PC4;
        RegWrite = 1'b0;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        EXTOp    = 1'b0;
        ALUSrcA  = SRCA_RS;
        ALUSrcB  = SRCB_RT;
        alu_sel  = ALU_NOP;
        illegal  = 1'b0;
        bus_err  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    IorD    = 1'b0;
                    bus_err = timeout;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        NPCOp   = NPC_PC4;
                        ALUSrcA = SRCA_PC;
                        ALUSrcB = SRCB_FOUR;
                        alu_sel = ALU_ADD;
                    end
                end
                ST_DECODE: begin
                    // branch offsets are signed, so the target uses sign extension
                    ALUSrcA = SRCA_PC;
                    ALUSrcB = SRCB_IMM_SH;
                    EXTOp   = 1'b1;
                    alu_sel = ALU_ADD;
                    if (d_j) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JUMP;
                    end else if (d_jal) begin
                        PCWrite  = 1'b1;
                        NPCOp    = NPC_JUMP;
                        RegWrite = 1'b1;
                        GPRSel   = GPR_R31;
                        WDSel    = WD_PC;
                    end else if (d_jr) begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_RS;
                    end else if (d_jalr) begin
                        PCWrite  = 1'b1;
                        NPCOp    = NPC_RS;
                        RegWrite = 1'b1;
                        GPRSel   = GPR_RD;
                        WDSel    = WD_PC;
                    end else if (d_illegal) begin
                        illegal = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (d_rtype) begin
                        ALUSrcA = d_shamt ? SRCA_SHAMT : SRCA_RS;
                        ALUSrcB = SRCB_RT;
                        alu_sel = d_alu;
                    end else if (d_imm) begin
                        ALUSrcA = SRCA_RS;
                        ALUSrcB = SRCB_IMM;
                        EXTOp   = d_ext;
                        alu_sel = d_alu;
                    end else if (d_lw || d_sw) begin
                        ALUSrcA = SRCA_RS;
                        ALUSrcB = SRCB_IMM;
                        EXTOp   = 1'b1;
                        alu_sel = ALU_ADD;
                    end else if (d_beq || d_bne) begin
                        ALUSrcA = SRCA_RS;
                        ALUSrcB = SRCB_RT;
                        alu_sel = ALU_SUB;
                        NPCOp   = NPC_BR;
                        PCWrite = (d_beq && Zero) || (d_bne && !Zero);
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = d_sw && !timeout;
                    bus_err  = timeout;
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    if (d_lw) begin
                        GPRSel = GPR_RT;
                        WDSel  = WD_MDR;
                    end else if (d_imm) begin
                        GPRSel = GPR_RT;
                        WDSel  = WD_ALU;
                    end else begin
                        GPRSel = GPR_RD;
                        WDSel  = WD_ALU;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALUOp = ALUOP_W'(alu_sel);
    assign state = rst ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the stimulus pushes one expected output
// snapshot per cycle, the monitor pops and compares on the falling edge.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] npc;
        logic       reg_write;
        logic [1:0] gpr;
        logic [1:0] wd;
        logic       ext;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic       illegal;
        logic       bus_err;
    } out_t;

    typedef struct {
        out_t  exp;
        out_t  mask;
        string name;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, IorD, IRWrite, PCWrite, RegWrite, EXTOp;
    logic       illegal, bus_err;
    logic [1:0] NPCOp, GPRSel, WDSel, ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic [2:0] state;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    mc_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (Op),
        .Funct     (Funct),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .NPCOp     (NPCOp),
        .RegWrite  (RegWrite),
        .GPRSel    (GPRSel),
        .WDSel     (WDSel),
        .EXTOp     (EXTOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    // expected snapshots per state (hand-written from the control tables)
    function automatic out_t fetch_e(input logic rdy);
        out_t o = '0;
        o.mem_req = 1'b1;
        if (rdy) begin
            o.ir_write = 1'b1;
            o.pc_write = 1'b1;
            o.srca     = 2'b01;
            o.srcb     = 2'b01;
            o.aluop    = 4'd1;
        end
        return o;
    endfunction

    function automatic out_t dec_e();
        out_t o = '0;
        o.st    = 3'd1;
        o.srca  = 2'b01;
        o.srcb  = 2'b11;
        o.aluop = 4'd1;
        return o;
    endfunction

    function automatic out_t ex_e(input logic [1:0] a, input logic [1:0] b,
                                  input logic ext, input logic [3:0] alu);
        out_t o = '0;
        o.st    = 3'd2;
        o.srca  = a;
        o.srcb  = b;
        o.ext   = ext;
        o.aluop = alu;
        return o;
    endfunction

    function automatic out_t mem_e(input logic wr);
        out_t o = '0;
        o.st        = 3'd3;
        o.mem_req   = 1'b1;
        o.iord      = 1'b1;
        o.mem_write = wr;
        return o;
    endfunction

    function automatic out_t wb_e(input logic [1:0] gpr, input logic [1:0] wd);
        out_t o = '0;
        o.st        = 3'd4;
        o.reg_write = 1'b1;
        o.gpr       = gpr;
        o.wd        = wd;
        return o;
    endfunction

    // monitor: compare the DUT against the oldest expected snapshot
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            entry_t e;
            out_t   g;
            e = sb.pop_front();
            g.st        = state;
            g.mem_req   = mem_req;
            g.mem_write = MemWrite;
            g.iord      = IorD;
            g.ir_write  = IRWrite;
            g.pc_write  = PCWrite;
            g.npc       = NPCOp;
            g.reg_write = RegWrite;
            g.gpr       = GPRSel;
            g.wd        = WDSel;
            g.ext       = EXTOp;
            g.srca      = ALUSrcA;
            g.srcb      = ALUSrcB;
            g.aluop     = ALUOp;
            g.illegal   = illegal;
            g.bus_err   = bus_err;
            n_checks++;
            if (((g ^ e.exp) & e.mask) != '0)
                $display("FAIL %s: got %07h expected %07h (mask %07h)",
                         e.name, g, e.exp, e.mask);
            else
                n_pass++;
        end
    end

    // drive one cycle of inputs and queue the expected outputs for it
    task automatic step(input logic rdy, input logic zr, input out_t e,
                        input out_t m, input string nm);
        entry_t ent;
        mem_ready = rdy;
        Zero      = zr;
        ent.exp   = e;
        ent.mask  = m;
        ent.name  = nm;
        sb.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    out_t full, dmask, t;

    initial begin
        full  = '1;
        dmask = '1;
        dmask.ext = 1'b0;          // immediate extension mode is not defined in DECODE
        rst = 1'b1; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;

        step(1, 0, '0, full, "reset0");
        step(1, 0, '0, full, "reset1");
        rst = 1'b0;

        // add
        Op = 6'h00; Funct = 6'h20;
        step(1, 0, fetch_e(1), full, "add F");
        step(1, 0, dec_e(), dmask, "add D");
        step(1, 0, ex_e(2'b00, 2'b00, 0, 4'd1), full, "add E");
        step(1, 0, wb_e(2'b00, 2'b00), full, "add WB");

        // sll uses shamt as operand A
        Op = 6'h00; Funct = 6'h00;
        step(1, 0, fetch_e(1), full, "sll F");
        step(1, 0, dec_e(), dmask, "sll D");
        step(1, 0, ex_e(2'b10, 2'b00, 0, 4'd8), full, "sll E");
        step(1, 0, wb_e(2'b00, 2'b00), full, "sll WB");

        // nor
        Op = 6'h00; Funct = 6'h27;
        step(1, 0, fetch_e(1), full, "nor F");
        step(1, 0, dec_e(), dmask, "nor D");
        step(1, 0, ex_e(2'b00, 2'b00, 0, 4'd7), full, "nor E");
        step(1, 0, wb_e(2'b00, 2'b00), full, "nor WB");

        // ori: zero-extended immediate, writes rt
        Op = 6'h0d; Funct = 6'h00;
        step(1, 0, fetch_e(1), full, "ori F");
        step(1, 0, dec_e(), dmask, "ori D");
        step(1, 0, ex_e(2'b00, 2'b10, 0, 4'd4), full, "ori E");
        step(1, 0, wb_e(2'b01, 2'b00), full, "ori WB");

        // addi: sign-extended
        Op = 6'h08;
        step(1, 0, fetch_e(1), full, "addi F");
        step(1, 0, dec_e(), dmask, "addi D");
        step(1, 0, ex_e(2'b00, 2'b10, 1, 4'd1), full, "addi E");
        step(1, 0, wb_e(2'b01, 2'b00), full, "addi WB");

        // lui
        Op = 6'h0f;
        step(1, 0, fetch_e(1), full, "lui F");
        step(1, 0, dec_e(), dmask, "lui D");
        step(1, 0, ex_e(2'b00, 2'b10, 0, 4'd10), full, "lui E");
        step(1, 0, wb_e(2'b01, 2'b00), full, "lui WB");

        // lw with three wait cycles in MEM (8 cycles total)
        Op = 6'h23;
        step(1, 0, fetch_e(1), full, "lw F");
        step(1, 0, dec_e(), dmask, "lw D");
        step(1, 0, ex_e(2'b00, 2'b10, 1, 4'd1), full, "lw E");
        for (int i = 0; i < 3; i++) step(0, 0, mem_e(0), full, "lw MEM wait");
        step(1, 0, mem_e(0), full, "lw MEM ready");
        step(1, 0, wb_e(2'b01, 2'b01), full, "lw WB");

        // sw
        Op = 6'h2b;
        step(1, 0, fetch_e(1), full, "sw F");
        step(1, 0, dec_e(), dmask, "sw D");
        step(1, 0, ex_e(2'b00, 2'b10, 1, 4'd1), full, "sw E");
        step(1, 0, mem_e(1), full, "sw MEM");

        // bne / beq, both Zero polarities
        Op = 6'h05;
        step(1, 0, fetch_e(1), full, "bne0 F");
        step(1, 0, dec_e(), dmask, "bne0 D");
        t = ex_e(2'b00, 2'b00, 0, 4'd2); t.pc_write = 1'b1; t.npc = 2'b01;
        step(1, 0, t, full, "bne Zero=0 E");
        step(1, 1, fetch_e(1), full, "bne1 F");
        step(1, 1, dec_e(), dmask, "bne1 D");
        t = ex_e(2'b00, 2'b00, 0, 4'd2); t.pc_write = 1'b0; t.npc = 2'b01;
        step(1, 1, t, full, "bne Zero=1 E");
        Op = 6'h04;
        step(1, 1, fetch_e(1), full, "beq1 F");
        step(1, 1, dec_e(), dmask, "beq1 D");
        t = ex_e(2'b00, 2'b00, 0, 4'd2); t.pc_write = 1'b1; t.npc = 2'b01;
        step(1, 1, t, full, "beq Zero=1 E");
        step(1, 0, fetch_e(1), full, "beq0 F");
        step(1, 0, dec_e(), dmask, "beq0 D");
        t = ex_e(2'b00, 2'b00, 0, 4'd2); t.pc_write = 1'b0; t.npc = 2'b01;
        step(1, 0, t, full, "beq Zero=0 E");

        // jumps finish in DECODE
        Op = 6'h03;
        step(1, 0, fetch_e(1), full, "jal F");
        t = dec_e(); t.pc_write = 1'b1; t.npc = 2'b10;
        t.reg_write = 1'b1; t.gpr = 2'b10; t.wd = 2'b10;
        step(1, 0, t, dmask, "jal D");
        Op = 6'h02;
        step(1, 0, fetch_e(1), full, "j F");
        t = dec_e(); t.pc_write = 1'b1; t.npc = 2'b10;
        step(1, 0, t, dmask, "j D");
        Op = 6'h00; Funct = 6'h08;
        step(1, 0, fetch_e(1), full, "jr F");
        t = dec_e(); t.pc_write = 1'b1; t.npc = 2'b11;
        step(1, 0, t, dmask, "jr D");
        Funct = 6'h09;
        step(1, 0, fetch_e(1), full, "jalr F");
        t = dec_e(); t.pc_write = 1'b1; t.npc = 2'b11;
        t.reg_write = 1'b1; t.gpr = 2'b00; t.wd = 2'b10;
        step(1, 0, t, dmask, "jalr D");

        // illegal opcode and illegal funct
        Op = 6'h3f; Funct = 6'h00;
        step(1, 0, fetch_e(1), full, "illop F");
        t = dec_e(); t.illegal = 1'b1;
        step(1, 0, t, dmask, "illegal op D");
        Op = 6'h00; Funct = 6'h3f;
        step(1, 0, fetch_e(1), full, "illfn F");
        t = dec_e(); t.illegal = 1'b1;
        step(1, 0, t, dmask, "illegal funct D");

        // FETCH timeout on the 4th wait cycle, then a clean retry of add
        Op = 6'h00; Funct = 6'h20;
        for (int i = 0; i < 3; i++) step(0, 0, fetch_e(0), full, "F wait");
        t = fetch_e(0); t.bus_err = 1'b1;
        step(0, 0, t, full, "F timeout bus_err");
        step(1, 0, fetch_e(1), full, "F retry");
        step(1, 0, dec_e(), dmask, "retry D");
        step(1, 0, ex_e(2'b00, 2'b00, 0, 4'd1), full, "retry E");
        step(1, 0, wb_e(2'b00, 2'b00), full, "retry WB");

        // mem_ready coinciding with the timeout cycle wins
        for (int i = 0; i < 3; i++) step(0, 0, fetch_e(0), full, "F wait2");
        step(1, 0, fetch_e(1), full, "F ready at limit");
        step(1, 0, dec_e(), dmask, "limit D");
        step(1, 0, ex_e(2'b00, 2'b00, 0, 4'd1), full, "limit E");
        step(1, 0, wb_e(2'b00, 2'b00), full, "limit WB");

        // MEM timeout abandons a store
        Op = 6'h2b;
        step(1, 0, fetch_e(1), full, "swto F");
        step(1, 0, dec_e(), dmask, "swto D");
        step(1, 0, ex_e(2'b00, 2'b10, 1, 4'd1), full, "swto E");
        for (int i = 0; i < 3; i++) step(0, 0, mem_e(1), full, "sw MEM wait");
        t = mem_e(0); t.bus_err = 1'b1;
        step(0, 0, t, full, "sw MEM timeout");
        step(1, 0, fetch_e(1), full, "after MEM timeout F");

        // reset in the middle of a store
        step(1, 0, dec_e(), dmask, "swrst D");
        step(1, 0, ex_e(2'b00, 2'b10, 1, 4'd1), full, "swrst E");
        step(0, 0, mem_e(1), full, "swrst MEM wait");
        rst = 1'b1;
        step(1, 0, '0, full, "reset mid MEM");
        rst = 1'b0;
        step(1, 0, fetch_e(1), full, "F after reset");

        begin
            int guard = 0;
            while (sb.size() != 0 && guard < 10) begin
                @(posedge clk);
                guard++;
            end
            if (sb.size() != 0) begin
                n_checks++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit. Replaces the single-cycle decoder for the multi-cycle datapath (shared ALU, instruction register IR, ALUOut and MDR registers, one memory port).
- A state machine sequences FETCH, DECODE, EXEC, MEM and WB. Memory accesses wait on a ready handshake.
- Extends the instruction set with bne, andi, slti, lui, nor, shifts, jr, jalr and jal. Adds illegal-opcode detection and a memory-timeout error.

Parameters:
- ALUOP_W, 4: width of ALUOp. Must be at least 4.
- MEM_TIMEOUT, 0: number of wait cycles without mem_ready before bus_err. 0 disables the timeout.
- CNT_W, 8: width of the wait counter. MEM_TIMEOUT must be below 2^CNT_W.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- Op  in  6  IR[31:26]; stable while IR is held.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- MemWrite  out  1  the request is a write.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR (and MDR) from memory read data.
- PCWrite  out  1  update PC.
- NPCOp  out  2  next-PC source: 00 PC+4, 01 branch target (ALUOut), 10 jump, 11 rs (register).
- RegWrite  out  1  register-file write.
- GPRSel  out  2  destination register: 00 rd, 01 rt, 10 r31.
- WDSel  out  2  write-data source: 00 ALUOut, 01 MDR, 10 PC.
- EXTOp  out  1  1 = sign-extend immediate, 0 = zero-extend.
- ALUSrcA  out  2  ALU A operand: 00 rs, 01 PC, 10 shamt.
- ALUSrcB  out  2  ALU B operand: 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ALUOp  out  ALUOP_W  ALU operation code from the package.
- illegal  out  1  one-cycle pulse: unsupported Op/Funct seen in DECODE.
- bus_err  out  1  one-cycle pulse: memory wait timed out.
- state  out  3  current FSM state, for debug.

Behaviour:
- Decoded instructions:
  - R-type: add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl, sllv, srlv, jr, jalr.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Standard MIPS encodings.
- State register: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Outputs are combinational from state, Op, Funct and Zero. All strobes are 0 unless listed below.
- While rst=1: state is FETCH and every output is forced to 0. The first cycle after reset is FETCH. A reset in any state aborts the instruction with no write.
- FETCH:
  - Drives mem_req=1, IorD=0.
  - If mem_ready: IRWrite=1, PCWrite=1, NPCOp=00 (ALUSrcA=01, ALUSrcB=01, ALU_ADD), then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Always drives ALUSrcA=01, ALUSrcB=11, ALU_ADD, so the branch target lands in ALUOut.
  - j: PCWrite, NPCOp=10, then FETCH.
  - jal: additionally RegWrite, GPRSel=10, WDSel=10, then FETCH.
  - jr: PCWrite, NPCOp=11, then FETCH.
  - jalr: PCWrite, NPCOp=11, RegWrite, GPRSel=00, WDSel=10, then FETCH.
  - illegal: pulse illegal, no writes, then FETCH. PC has already advanced.
  - All other instructions go to EXEC.
- EXEC:
  - R-type ALU operations: ALUSrcA=00, or 10 for sll/srl; ALUSrcB=00. Then WB.
  - Immediate ALU operations: ALUSrcB=10. EXTOp=1 for addi and slti, 0 for andi, ori and lui. Then WB.
  - lw/sw: ALU_ADD, ALUSrcB=10, EXTOp=1. Then MEM.
  - beq/bne: ALU_SUB on rs, rt. PCWrite=(beq&Zero)|(bne&~Zero), NPCOp=01. Then FETCH.
- MEM:
  - Drives mem_req=1, IorD=1, MemWrite=sw.
  - On mem_ready: lw goes to WB (MDR loaded via IRWrite path gating is external); sw goes to FETCH.
  - Otherwise stay in MEM.
- WB:
  - RegWrite=1, then FETCH.
  - lw: GPRSel=01, WDSel=01.
  - Immediate ALU operations: GPRSel=01, WDSel=00.
  - R-type: GPRSel=00, WDSel=00.
- Latency with mem_ready held high:
  - 2 cycles: j, jal, jr, jalr.
  - 3 cycles: beq, bne.
  - 4 cycles: R-type, immediate ALU operations, sw.
  - 5 cycles: lw.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH or MEM and on mem_ready. Increments each waiting cycle, saturating.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT: pulse bus_err, go to FETCH with no PCWrite, IRWrite or MemWrite.
  - A FETCH timeout therefore retries the same PC. A MEM timeout abandons the load/store.
  - mem_ready in the same cycle as the timeout wins; no bus_err is raised.
- mem_req stays high while waiting. Op and Funct are not re-sampled in MEM or WB; IR is held.

Decomposition:
- Package mc_ctrl_pkg holds:
  - ALU codes: NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, NOR 7, SLL 8, SRL 9, LUI 10.
  - Opcode and funct constants.
  - State encodings.
  - NPCOp, GPRSel, WDSel, ALUSrcA and ALUSrcB codes.
- Sub-module mc_decode: purely combinational classification of Op/Funct into instruction classes, ALU code, EXTOp and illegal. mc_ctrl contains the FSM, wait counter and output muxing.

Test Plan:
- add (Op=0, Funct=0x20), mem_ready=1 → states F,D,E,WB,F; RegWrite=1 only in WB with GPRSel=00, WDSel=00; ALUOp=1 in EXEC.
- lw (Op=0x23), mem_ready low 3 cycles in MEM → MEM held 4 cycles with mem_req=1, IorD=1, MemWrite=0; WB with GPRSel=01, WDSel=01; total 8 cycles.
- bne (Op=0x05): Zero=0 → PCWrite=1, NPCOp=01 in EXEC. Repeat with Zero=1 → PCWrite=0. beq mirrors this.
- jal (Op=0x03) → DECODE drives PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10; next state FETCH.
- Op=0x3F → illegal pulses one cycle in DECODE; no RegWrite or MemWrite; next state FETCH.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH → bus_err pulses on the 4th wait cycle, no IRWrite or PCWrite, FETCH re-entered. rst=1 asserted mid-MEM of sw → MemWrite=0 that cycle and state=FETCH next cycle.
